// File: rtl/alu_result_unloader.sv
// +--------------------------------------------------------------------------+
// | alu_result_unloader                                                      |
// | Captures the 64-bit ALU result and returns it to the 32-bit bus as       |
// | LO (and HI for MUL/DIV) beats.                                           |
// | Optional: ALU_UNLOAD_ZERO_FLAG_EN adds the zero_flag output.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_result_unloader #(
  parameter logic [4:0] MUL_OP = 5'b00010,
  parameter logic [4:0] DIV_OP = 5'b00011,
  parameter int         CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      alu_c,
  input  logic [4:0]       alu_op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      bus_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_hi,
  output logic             out_last,
  output logic [31:0]      hi_reg,
  output logic [31:0]      lo_reg,
`ifdef ALU_UNLOAD_ZERO_FLAG_EN
  output logic             zero_flag,
`endif
  output logic [CNT_W-1:0] result_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND_LO = 2'd1,
    S_SEND_HI = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [63:0]      r_z;
  logic             r_wide;
  logic [31:0]      r_bus_out;
  logic             r_out_valid;
  logic             r_out_hi;
  logic             r_out_last;
  logic [31:0]      r_hi_reg;
  logic [31:0]      r_lo_reg;
  logic [CNT_W-1:0] r_count;
  logic             w_wide;

  assign w_wide = (alu_op == MUL_OP) || (alu_op == DIV_OP);

  // Gated by rst_n so the port reads 0 while reset is held.
  assign in_ready     = (r_state == S_IDLE) && rst_n;
  assign bus_out      = r_bus_out;
  assign out_valid    = r_out_valid;
  assign out_hi       = r_out_hi;
  assign out_last     = r_out_last;
  assign hi_reg       = r_hi_reg;
  assign lo_reg       = r_lo_reg;
  assign result_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_z         <= 64'd0;
      r_wide      <= 1'b0;
      r_bus_out   <= 32'd0;
      r_out_valid <= 1'b0;
      r_out_hi    <= 1'b0;
      r_out_last  <= 1'b0;
      r_hi_reg    <= 32'd0;
      r_lo_reg    <= 32'd0;
      r_count     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_z         <= alu_c;
            r_wide      <= w_wide;
            r_bus_out   <= alu_c[31:0];
            r_out_valid <= 1'b1;
            r_out_hi    <= 1'b0;
            r_out_last  <= !w_wide;
            r_state     <= S_SEND_LO;
            if (w_wide) begin
              r_hi_reg <= alu_c[63:32];
              r_lo_reg <= alu_c[31:0];
            end
          end
        end
        S_SEND_LO: begin
          if (out_ready) begin
            if (r_wide) begin
              r_bus_out  <= r_z[63:32];
              r_out_hi   <= 1'b1;
              r_out_last <= 1'b1;
              r_state    <= S_SEND_HI;
            end else begin
              r_bus_out   <= 32'd0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_count     <= r_count + C_CNT_ONE;
              r_state     <= S_IDLE;
            end
          end
        end
        S_SEND_HI: begin
          if (out_ready) begin
            r_bus_out   <= 32'd0;
            r_out_valid <= 1'b0;
            r_out_hi    <= 1'b0;
            r_out_last  <= 1'b0;
            r_count     <= r_count + C_CNT_ONE;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_UNLOAD_ZERO_FLAG_EN
  logic r_zero_flag;
  assign zero_flag = r_zero_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero_flag <= 1'b0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_zero_flag <= w_wide ? (alu_c == 64'd0) : (alu_c[31:0] == 32'd0);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_result_unloader.sv
// Testbench for alu_result_unloader: randomized results against a beat-level
// reference model of the unloader.
`default_nettype none

module tb_alu_result_unloader;

  localparam logic [4:0] MUL_OP = 5'b00010;
  localparam logic [4:0] DIV_OP = 5'b00011;
  localparam int         CNT_W  = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [63:0]      alu_c;
  logic [4:0]       alu_op;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      bus_out;
  logic             out_valid;
  logic             out_ready;
  logic             out_hi;
  logic             out_last;
  logic [31:0]      hi_reg;
  logic [31:0]      lo_reg;
  logic [CNT_W-1:0] result_count;
`ifdef ALU_UNLOAD_ZERO_FLAG_EN
  logic             zero_flag;
`endif

  alu_result_unloader #(.MUL_OP(MUL_OP), .DIV_OP(DIV_OP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .alu_c(alu_c), .alu_op(alu_op),
    .in_valid(in_valid), .in_ready(in_ready), .bus_out(bus_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_hi(out_hi),
    .out_last(out_last), .hi_reg(hi_reg), .lo_reg(lo_reg),
`ifdef ALU_UNLOAD_ZERO_FLAG_EN
    .zero_flag(zero_flag),
`endif
    .result_count(result_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0]      m_hi, m_lo;
  logic [CNT_W-1:0] m_count;
  logic             m_zero;
  logic [31:0]      exp_data[$];
  logic             exp_hi[$], exp_last[$];

  // Observed beats of the last delivery
  logic [31:0]      obs_data[$];
  logic             obs_hi[$], obs_last[$];
  logic             timed_out;

  function automatic logic is_wide(input logic [4:0] op);
    return (op == MUL_OP) || (op == DIV_OP);
  endfunction

  function automatic logic [4:0] rand_narrow_op();
    logic [4:0] op;
    op = 5'($urandom);
    while (is_wide(op)) op = 5'($urandom);
    return op;
  endfunction

  // Expected beats and architectural effects of one result.
  task automatic model_result(input logic [4:0] op, input logic [63:0] c);
    exp_data.delete(); exp_hi.delete(); exp_last.delete();
    exp_data.push_back(c[31:0]);
    exp_hi.push_back(1'b0);
    exp_last.push_back(!is_wide(op));
    if (is_wide(op)) begin
      exp_data.push_back(c[63:32]);
      exp_hi.push_back(1'b1);
      exp_last.push_back(1'b1);
      m_hi = c[63:32];
      m_lo = c[31:0];
      m_zero = (c == 64'd0);
    end else begin
      m_zero = (c[31:0] == 32'd0);
    end
    m_count = m_count + 1'b1;
  endtask

  function automatic logic beats_bad();
    if (timed_out || obs_data.size() != exp_data.size()) return 1'b1;
    foreach (exp_data[k])
      if (obs_data[k] !== exp_data[k] || obs_hi[k] !== exp_hi[k] || obs_last[k] !== exp_last[k])
        return 1'b1;
    return 1'b0;
  endfunction

  // Offers one result and collects its beats with out_ready held high.
  task automatic deliver(input logic [4:0] op, input logic [63:0] c);
    int guard;
    obs_data.delete(); obs_hi.delete(); obs_last.delete();
    timed_out = 1'b0;
    guard = 0;
    while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
    in_valid = 1'b1; alu_c = c; alu_op = op; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; alu_c = {$urandom, $urandom}; alu_op = 5'($urandom);
    for (int g = 0; g < 20; g++) begin
      if (out_valid) begin
        obs_data.push_back(bus_out);
        obs_hi.push_back(out_hi);
        obs_last.push_back(out_last);
        if (out_last) begin @(negedge clk); return; end
      end
      @(negedge clk);
    end
    timed_out = 1'b1;
  endtask

  task automatic model_reset();
    m_hi = 32'd0; m_lo = 32'd0; m_count = '0; m_zero = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; alu_c = '0; alu_op = '0;
    model_reset();
    #1;
    n_tests++;
    if ({out_valid, out_hi, out_last, bus_out, hi_reg, lo_reg, result_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: valid=%b hi=%b last=%b bus=%h hi_reg=%h lo_reg=%h cnt=%0d, required all 0",
               out_valid, out_hi, out_last, bus_out, hi_reg, lo_reg, result_count);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    // Load a wide result, then reset asynchronously mid-cycle while the bus is active.
    deliver(MUL_OP, 64'hDEAD_BEEF_1234_5678);
    in_valid = 1'b1; alu_c = 64'h1111_2222_3333_4444; alu_op = MUL_OP; out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if ({out_valid, out_hi, out_last, bus_out, hi_reg, lo_reg, result_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: valid=%b hi=%b last=%b bus=%h hi_reg=%h lo_reg=%h cnt=%0d, required all 0",
               out_valid, out_hi, out_last, bus_out, hi_reg, lo_reg, result_count);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wide();
    model_result(DIV_OP, 64'h0000_0002_0000_0007);
    deliver(DIV_OP, 64'h0000_0002_0000_0007);
    n_tests++;
    if (beats_bad()) begin
      n_fail++;
      $display("FAIL wide_beats: got %0d beats first=%h, required %0d beats %h then %h",
               obs_data.size(), obs_data.size() > 0 ? obs_data[0] : 32'h0, exp_data.size(), exp_data[0], exp_data[1]);
    end
    n_tests++;
    if (hi_reg !== 32'd2 || lo_reg !== 32'd7 || result_count !== m_count) begin
      n_fail++;
      $display("FAIL wide_regs: hi=%h lo=%h cnt=%0d, required 2/7/%0d", hi_reg, lo_reg, result_count, m_count);
    end
  endtask

  task automatic test_narrow();
    model_result(5'b00100, 64'h0000_0000_0000_00F0);
    deliver(5'b00100, 64'h0000_0000_0000_00F0);
    n_tests++;
    if (beats_bad()) begin
      n_fail++;
      $display("FAIL narrow_beats: got %0d beats first=%h, required 1 beat %h last=1",
               obs_data.size(), obs_data.size() > 0 ? obs_data[0] : 32'h0, exp_data[0]);
    end
    n_tests++;
    if (hi_reg !== m_hi || lo_reg !== m_lo || result_count !== m_count) begin
      n_fail++;
      $display("FAIL narrow_regs: hi=%h lo=%h cnt=%0d, required %h/%h/%0d",
               hi_reg, lo_reg, result_count, m_hi, m_lo, m_count);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] c;
    logic        bad;
    c = {$urandom, $urandom};
    model_result(MUL_OP, c);
    out_ready = 1'b0; in_valid = 1'b1; alu_c = c; alu_op = MUL_OP;
    @(negedge clk);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || bus_out !== c[31:0] || out_hi !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b0)
        bad = 1'b1;
      in_valid = 1'($urandom); alu_c = {$urandom, $urandom}; alu_op = 5'($urandom);
      @(negedge clk);
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL stall_lo: bus=%h hi=%b last=%b in_ready=%b, required %h/0/0/0",
               bus_out, out_hi, out_last, in_ready, c[31:0]);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (out_valid !== 1'b1 || bus_out !== c[63:32] || out_hi !== 1'b1 || out_last !== 1'b1 || in_ready !== 1'b0)
        bad = 1'b1;
      alu_c = {$urandom, $urandom}; alu_op = 5'($urandom);
      @(negedge clk);
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL stall_hi: bus=%h hi=%b last=%b in_ready=%b, required %h/1/1/0",
               bus_out, out_hi, out_last, in_ready, c[63:32]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || hi_reg !== m_hi || lo_reg !== m_lo || result_count !== m_count) begin
      n_fail++;
      $display("FAIL stall_done: valid=%b hi=%h lo=%h cnt=%0d, required 0/%h/%h/%0d",
               out_valid, hi_reg, lo_reg, result_count, m_hi, m_lo, m_count);
    end
    // out_ready with nothing pending must not advance anything.
    repeat (3) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result_count !== m_count) begin
      n_fail++;
      $display("FAIL idle_ready: valid=%b in_ready=%b cnt=%0d, required 0/1/%0d",
               out_valid, in_ready, result_count, m_count);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; in_valid = 1'b1; alu_c = {$urandom, $urandom}; alu_op = DIV_OP;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++;
    if (out_hi !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reach_hi: out_hi=%b out_valid=%b, required 1/1", out_hi, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (out_valid !== 1'b0 || hi_reg !== 32'd0 || lo_reg !== 32'd0 || result_count !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b hi=%h lo=%h cnt=%0d, required 0/0/0/0",
               out_valid, hi_reg, lo_reg, result_count);
    end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || result_count !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_after: valid=%b cnt=%0d in_ready=%b, required 0/0/1", out_valid, result_count, in_ready);
    end
  endtask

  task automatic test_wrap();
    logic        bad;
    logic [63:0] c;
    logic [4:0]  op;
    bad = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i == 0)      c = 64'd0;
      else if (i == 1) c = 64'd1;
      else             c = {$urandom, $urandom};
      op = rand_narrow_op();
      model_result(op, c);
      deliver(op, c);
      if (beats_bad() || hi_reg !== m_hi || lo_reg !== m_lo) bad = 1'b1;
`ifdef ALU_UNLOAD_ZERO_FLAG_EN
      if (i < 2) begin
        n_tests++;
        if (zero_flag !== m_zero) begin
          n_fail++;
          $display("FAIL zero_flag_%0d: got %b, required %b", i, zero_flag, m_zero);
        end
      end
`endif
      if (i == 254) begin
        n_tests++;
        if (result_count !== m_count) begin
          n_fail++;
          $display("FAIL count_pre_wrap: got %0d, required %0d", result_count, m_count);
        end
      end
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL wrap_beats: a narrow delivery produced wrong beats or touched hi/lo");
    end
    n_tests++;
    if (result_count !== m_count) begin
      n_fail++;
      $display("FAIL count_wrap: got %0d, required %0d", result_count, m_count);
    end
  endtask

  task automatic test_random();
    logic [63:0] c;
    logic [4:0]  op;
    for (int i = 0; i < 40; i++) begin
      c  = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) c[31:0] = 32'd0;
      op = ($urandom_range(0, 1) == 1) ? (($urandom_range(0, 1) == 1) ? MUL_OP : DIV_OP) : rand_narrow_op();
      model_result(op, c);
      deliver(op, c);
      n_tests++;
      if (beats_bad() || hi_reg !== m_hi || lo_reg !== m_lo || result_count !== m_count) begin
        n_fail++;
        $display("FAIL random_%0d: op=%h c=%h beats=%0d hi=%h lo=%h cnt=%0d, required beats=%0d hi=%h lo=%h cnt=%0d",
                 i, op, c, obs_data.size(), hi_reg, lo_reg, result_count, exp_data.size(), m_hi, m_lo, m_count);
      end
`ifdef ALU_UNLOAD_ZERO_FLAG_EN
      n_tests++;
      if (zero_flag !== m_zero) begin
        n_fail++;
        $display("FAIL random_zero_%0d: got %b, required %b", i, zero_flag, m_zero);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_wide();
    test_narrow();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
